// File: rtl/div_ctrl_pkg.sv
// Shared defines for the clock-divider controller.
//   DIV_SIZE : default width of the divide ratio and of the period counter.
package div_ctrl_pkg;
  localparam int DIV_SIZE = 8;
endpackage

// File: rtl/div_ctrl.sv
// div_ctrl: accepts a divide ratio N and hands it to the even/odd divider
// stages. A new ratio takes effect only at a period boundary of the current
// ratio, so no output period is ever cut short.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   load_valid/load_div   : offered divide ratio N (handshake with load_ready)
//   load_ready            : a ratio can be accepted this cycle
//   err                   : one-cycle pulse, an accepted ratio of 0 was rejected
//   P                     : divide ratio driven to the divider stages
//   not_zero              : 0 = bypass (N = 1), 1 = divided output
//   en_even, en_odd       : divider stage enables
//   sel_odd               : output mux select (1 = odd stage)
//   stage_rst             : one-cycle reset pulse to the divider stages
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int SIZE = DIV_SIZE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_valid,
  input  logic [SIZE-1:0] load_div,
  output logic            load_ready,
  output logic            err,
  output logic [SIZE-1:0] P,
  output logic            not_zero,
  output logic            en_even,
  output logic            en_odd,
  output logic            sel_odd,
  output logic            stage_rst
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_APPLY = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  localparam logic [SIZE-1:0] ONE = SIZE'(1);

  state_t          state, state_nx;
  logic [SIZE-1:0] pend;
  logic [SIZE-1:0] pcnt;
  logic            boundary;
  logic            load_nz;

  assign boundary = (pcnt == '0);
  assign load_nz  = (load_div != '0);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    load_ready = 1'b0;
    stage_rst  = 1'b0;
    en_even    = 1'b0;
    en_odd     = 1'b0;
    case (state)
      S_IDLE: begin
        load_ready = 1'b1;
        if (load_valid && load_nz) state_nx = S_WAIT;
      end
      S_WAIT: begin
        // the previous ratio keeps running until its period completes
        en_even = not_zero & ~P[0];
        en_odd  = not_zero &  P[0];
        if (boundary) state_nx = S_APPLY;
      end
      S_APPLY: begin
        stage_rst = 1'b1;
        state_nx  = S_RUN;
      end
      S_RUN: begin
        load_ready = 1'b1;
        en_even    = not_zero & ~P[0];
        en_odd     = not_zero &  P[0];
        if (load_valid && load_nz) state_nx = S_WAIT;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // ratio registers, error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      pend     <= '0;
      P        <= ONE;
      not_zero <= 1'b0;
      sel_odd  <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= load_valid & load_ready & ~load_nz;
      if (load_valid && load_ready && load_nz) pend <= load_div;
      // new ratio becomes visible during the APPLY cycle
      if (state == S_WAIT && boundary) begin
        P        <= pend;
        not_zero <= (pend != ONE);
        sel_odd  <= pend[0] & (pend != ONE);
      end
    end
  end

  // period counter: counts N-1 down to 0; P >= 1 always, so P-1 never wraps
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
    end else begin
      case (state)
        S_IDLE:  pcnt <= '0;
        S_APPLY: pcnt <= P - 1'b1;
        default: pcnt <= boundary ? P - 1'b1 : pcnt - 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl (SIZE = 8): a cycle-by-cycle vector table for
// the main switching scenarios, plus hand-written sequences for the long
// N = 255 period, reset during WAIT and reset-vs-load priority.
module tb_div_ctrl;

  localparam int SIZE = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            load_valid;
  logic [SIZE-1:0] load_div;
  logic            load_ready, err, not_zero, en_even, en_odd, sel_odd, stage_rst;
  logic [SIZE-1:0] P;

  int checks = 0;
  int errors = 0;

  div_ctrl #(.SIZE(SIZE)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_div(load_div),
    .load_ready(load_ready), .err(err), .P(P), .not_zero(not_zero),
    .en_even(en_even), .en_odd(en_odd), .sel_odd(sel_odd), .stage_rst(stage_rst)
  );

  always #5 clk = ~clk;

  // {rdy, err, P, nz, ee, eo, sel, srst}
  logic [14:0] act;
  assign act = {load_ready, err, P, not_zero, en_even, en_odd, sel_odd, stage_rst};

  function automatic logic [14:0] o(input logic rdy, input logic e, input logic [7:0] p,
                                    input logic nz, input logic ee, input logic eo,
                                    input logic sel, input logic srst);
    return {rdy, e, p, nz, ee, eo, sel, srst};
  endfunction

  typedef struct {
    logic        rst;
    logic        lv;
    logic [7:0]  div;
    logic [14:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic lv, input logic [7:0] div,
                     input logic [14:0] exp, input string name);
    vec_t v;
    v.rst = rst; v.lv = lv; v.div = div; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  // drive inputs, clock once, sample 1 time unit after the edge
  task automatic cyc(input logic rst, input logic lv, input logic [7:0] div);
    reset = rst; load_valid = lv; load_div = div;
    @(posedge clk); #1;
  endtask

  logic [14:0] IDLE_O;
  int wait_cnt;
  logic err_seen, bad_seen;

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_div = '0;
    IDLE_O = o(1,0,1,0,0,0,0,0);

    add(1,0,0,  IDLE_O,               "reset");
    for (int i = 0; i < 5; i++) add(0,0,0, IDLE_O, "idle");
    // N = 6 from IDLE: WAIT, APPLY, RUN
    add(0,1,6,  o(0,0,1,0,0,0,0,0),   "n6_wait");
    add(0,0,0,  o(0,0,6,1,0,0,0,1),   "n6_apply");
    add(0,0,0,  o(1,0,6,1,1,0,0,0),   "n6_run");
    // zero divisor in RUN: err pulse only
    add(0,1,0,  o(1,1,6,1,1,0,0,0),   "zero_err");
    add(0,0,0,  o(1,0,6,1,1,0,0,0),   "zero_clr");
    // N = 5 accepted with pcnt = 3: three WAIT cycles keep N = 6 running
    add(0,1,5,  o(0,0,6,1,1,0,0,0),   "n5_wait1");
    add(0,0,0,  o(0,0,6,1,1,0,0,0),   "n5_wait2");
    add(0,0,0,  o(0,0,6,1,1,0,0,0),   "n5_wait3");
    add(0,0,0,  o(0,0,5,1,0,0,1,1),   "n5_apply");
    add(0,0,0,  o(1,0,5,1,0,1,1,0),   "n5_run");
    add(0,0,0,  o(1,0,5,1,0,1,1,0),   "n5_run2");
    // RUN N = 5, load N = 4 at pcnt = 3; load during WAIT ignored
    add(0,1,4,  o(0,0,5,1,0,1,1,0),   "n4_wait1");
    add(0,1,9,  o(0,0,5,1,0,1,1,0),   "n4_ignore");
    add(0,0,0,  o(0,0,5,1,0,1,1,0),   "n4_wait3");
    add(0,0,0,  o(0,0,4,1,0,0,0,1),   "n4_apply");
    add(0,0,0,  o(1,0,4,1,1,0,0,0),   "n4_run");
    // N = 1: bypass, enables off
    add(0,1,1,  o(0,0,4,1,1,0,0,0),   "n1_wait1");
    add(0,0,0,  o(0,0,4,1,1,0,0,0),   "n1_wait2");
    add(0,0,0,  o(0,0,4,1,1,0,0,0),   "n1_wait3");
    add(0,0,0,  o(0,0,1,0,0,0,0,1),   "n1_apply");
    add(0,0,0,  o(1,0,1,0,0,0,0,0),   "n1_run");
    // N = 255 from N = 1: boundary is immediate
    add(0,1,255,o(0,0,1,0,0,0,0,0),   "n255_wait");
    add(0,0,0,  o(0,0,255,1,0,0,1,1), "n255_apply");
    add(0,0,0,  o(1,0,255,1,0,1,1,0), "n255_run");

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].lv, tbl[i].div);
      chk(tbl[i].name, 32'(act), 32'(tbl[i].exp));
    end

    // RUN N = 255 with pcnt = 254: load N = 2 -> 254 WAIT cycles,
    // a second load held during WAIT must be ignored
    cyc(0,1,2);
    err_seen = err;
    wait_cnt = 1;
    load_div = 8'd3;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (err) err_seen = 1'b1;
      if (stage_rst) break;
      wait_cnt++;
    end
    load_valid = 1'b0;
    chk("n255_wait_len", 32'(wait_cnt), 32'd254);
    chk("n255_no_err", 32'(err_seen), 32'd0);
    chk("n2_apply_p", 32'(P), 32'd2);
    cyc(0,0,0);
    chk("n2_run", 32'(act), 32'(o(1,0,2,1,1,0,0,0)));

    // reset during WAIT discards the pending ratio
    cyc(0,1,7);
    chk("n7_wait", 32'(act), 32'(o(0,0,2,1,1,0,0,0)));
    cyc(1,0,0);
    chk("rst_in_wait", 32'(act), 32'(IDLE_O));
    bad_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(0,0,0);
      if (act !== IDLE_O) bad_seen = 1'b1;
    end
    chk("pend_lost", 32'(bad_seen), 32'd0);

    // zero divisor in IDLE
    cyc(0,1,0);
    chk("idle_zero_err", 32'(act), 32'(o(1,1,1,0,0,0,0,0)));
    cyc(0,0,0);
    chk("idle_zero_clr", 32'(act), 32'(IDLE_O));

    // reset wins over a simultaneous load
    cyc(1,1,5);
    chk("rst_prio", 32'(act), 32'(IDLE_O));
    cyc(0,0,0);
    chk("rst_prio_idle", 32'(act), 32'(IDLE_O));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter: SIZE, taken from the shared defines file, default 8, divisor and counter width.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 load_valid  input  1  a new divisor is offered.
REQ-005 load_div  input  SIZE  requested divide ratio N.
REQ-006 load_ready  output  1  controller can accept a divisor; transfer occurs when load_valid & load_ready at posedge.
REQ-007 err  output  1  one-cycle pulse: an accepted divisor was 0 and was rejected.
REQ-008 P  output  SIZE  divide ratio driven to the divider stages.
REQ-009 not_zero  output  1  0 = bypass (output follows clk), 1 = divided output.
REQ-010 en_even  output  1  enable for the even divider stage.
REQ-011 en_odd  output  1  enable for the odd divider stage.
REQ-012 sel_odd  output  1  output-mux select: 1 = odd stage, 0 = even stage.
REQ-013 stage_rst  output  1  one-cycle reset pulse to the divider stages.

Function
REQ-014 FSM states: IDLE (no divisor active), WAIT (pending divisor, waiting for boundary), APPLY (switch cycle), RUN (divisor active).
REQ-015 load_ready = 1 in IDLE and RUN; 0 in WAIT and APPLY.
REQ-016 On accept with load_div = 0: err = 1 in the next cycle only; state, pend register and all divider outputs unchanged.
REQ-017 On accept with load_div != 0: latch into pend; next state WAIT.
REQ-018 Period counter pcnt (SIZE bits): in RUN and WAIT, decrement each cycle; on 0, reload active N-1; in IDLE it holds 0.
REQ-019 Boundary = pcnt == 0; WAIT -> APPLY on the posedge where pcnt == 0; from IDLE the boundary holds immediately.
REQ-020 APPLY lasts exactly one cycle: stage_rst = 1, en_even = en_odd = 0, P = pend, not_zero = (pend != 1), sel_odd = pend[0] & (pend != 1); pcnt loaded with pend-1.
REQ-021 APPLY -> RUN unconditionally; in RUN en_even = not_zero & ~P[0], en_odd = not_zero & P[0], stage_rst = 0.
REQ-022 Latency: acceptance from IDLE -> WAIT 1 cycle, APPLY 2nd cycle, enables high from 3rd cycle.
REQ-023 N = 1: not_zero = 0, both enables 0, pcnt stays 0 (boundary every cycle).
REQ-024 N = 2^SIZE-1 is supported; no width overflow on pend-1 or reload.
REQ-025 Accept in RUN: previous P/enables remain active through WAIT until boundary; no partial period is cut.
REQ-026 load_valid while load_ready = 0 is ignored (not queued); err stays 0.

Reset
REQ-027 reset (sync) forces: state IDLE, P = 1, not_zero = 0, en_even = 0, en_odd = 0, sel_odd = 0, stage_rst = 0, err = 0, load_ready = 1, pcnt = 0, pend = 0.
REQ-028 reset mid-WAIT/APPLY discards pend; reset has priority over a simultaneous load.

Structure
REQ-029 SIZE lives in the shared defines file; the state encodings are localparams in this block.
REQ-030 Single module, no sub-modules; pcnt may be its own always block.

Verification
REQ-031 Reset, then idle 5 cycles -> P = 1, not_zero = 0, enables 0, load_ready = 1.
REQ-032 From IDLE, load N = 6 -> WAIT, then APPLY with stage_rst = 1, P = 6; en_even = 1, sel_odd = 0 from cycle 3.
REQ-033 RUN N = 5, load N = 4 when pcnt = 3 -> switch waits 3 cycles, then APPLY, P = 4, en_even = 1, en_odd = 0.
REQ-034 Load N = 0 -> err high exactly 1 cycle, outputs and state unchanged; load N = 1 -> not_zero = 0, enables 0.
REQ-035 Load N = 255 (SIZE = 8) -> pcnt reloads 254 each period; second load during WAIT is ignored.
REQ-036 Assert reset during WAIT -> next cycle all outputs at reset values, pending N lost.
